// File: rtl/ofd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ofd_pkg
//  Description : Shared constants for the output flip-flop bank.
//  Revision    : 1.0 - initial release
// ============================================================================
package ofd_pkg;

  localparam int MODE_DIRECT = 0;
  localparam int MODE_DBUF   = 1;
  localparam int DEPTH_MAX   = 4;
  localparam int CNT_W       = 8;

endpackage : ofd_pkg
`default_nettype wire

// File: rtl/ofd_stage.sv
`default_nettype none
// ============================================================================
//  Module      : ofd_stage
//  Description : One pipeline register with clock enable, synchronous clear
//                and asynchronous active-low reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module ofd_stage #(
  parameter int            SW      = 1,
  parameter logic [SW-1:0] RST_VAL = '0
) (
  input  logic          CK,
  input  logic          RN,
  input  logic          CE,
  input  logic          CLR,
  input  logic [SW-1:0] D,
  output logic [SW-1:0] Q
);

  logic [SW-1:0] data_q;

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      data_q <= RST_VAL;
    end else if (CLR) begin
      data_q <= RST_VAL;
    end else if (CE) begin
      data_q <= D;
    end
  end

  assign Q = data_q;

endmodule : ofd_stage
`default_nettype wire

// File: rtl/ofd_bank.sv
`default_nettype none
// ============================================================================
//  Module      : ofd_bank
//  Description : NCH x W output register bank with DEPTH-stage pipeline and an
//                optional shadow/commit front end for glitch-free updates.
//  Revision    : 1.0 - initial release
// ============================================================================
module ofd_bank
  import ofd_pkg::*;
#(
  parameter int           NCH   = 3,
  parameter int           W     = 1,
  parameter int           DEPTH = 1,
  parameter int           MODE  = 0,
  parameter logic [W-1:0] INIT  = '0
) (
  input  logic               CK,
  input  logic               RN,
  input  logic               CE,
  input  logic               CLR,
  input  logic [NCH*W-1:0]   D,
  input  logic               VLD_IN,
  input  logic [NCH-1:0]     OE_IN,
  input  logic               LD,
  input  logic [NCH-1:0]     WEN,
  input  logic               COMMIT,
  output logic [NCH*W-1:0]   Q,
  output logic [NCH-1:0]     OE,
  output logic               VLD,
  output logic               PEND,
  output logic [CNT_W-1:0]   UPD_CNT
);

  localparam int DW = NCH * W;
  localparam int SW = DW + NCH + 1;
  // Stage word layout, MSB first: {data, output enables, valid tag}
  localparam logic [SW-1:0] STAGE_RST = {{NCH{INIT}}, {NCH{1'b0}}, 1'b0};

  if ((DEPTH < 1) || (DEPTH > DEPTH_MAX) || (MODE < MODE_DIRECT) || (MODE > MODE_DBUF)) begin : g_bad_param
    $error("ofd_bank: DEPTH must be 1..%0d and MODE 0..1", DEPTH_MAX);
  end

  logic [DW-1:0]    shadow_q, shadow_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SW-1:0]    stage0_d;
  logic [SW-1:0]    stage_q [DEPTH];

  always_comb begin
    shadow_d = shadow_q;
    pend_d   = pend_q;
    cnt_d    = cnt_q;
    stage0_d = stage_q[0];
    if (MODE == MODE_DIRECT) begin
      stage0_d = {D, OE_IN, VLD_IN};
      if (VLD_IN) begin
        cnt_d = cnt_q + 8'd1;
      end
    end else begin
      // Untagged cycles keep data/OE so the pins hold between commits
      stage0_d = {stage_q[0][SW-1:1], 1'b0};
      if (COMMIT) begin
        stage0_d = {shadow_q, OE_IN, 1'b1};
        pend_d   = 1'b0;
        cnt_d    = cnt_q + 8'd1;
      end
      if (LD) begin
        for (int i = 0; i < NCH; i++) begin
          if (WEN[i]) begin
            shadow_d[i*W +: W] = D[i*W +: W];
          end
        end
        pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      shadow_q <= {NCH{INIT}};
      pend_q   <= 1'b0;
      cnt_q    <= '0;
    end else if (CLR) begin
      shadow_q <= {NCH{INIT}};
      pend_q   <= 1'b0;
      cnt_q    <= '0;
    end else if (CE) begin
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [SW-1:0] stage_d;
    if (k == 0) begin : g_head
      assign stage_d = stage0_d;
    end else begin : g_tail
      assign stage_d = stage_q[k-1];
    end
    ofd_stage #(
      .SW      (SW),
      .RST_VAL (STAGE_RST)
    ) u_stage (
      .CK  (CK),
      .RN  (RN),
      .CE  (CE),
      .CLR (CLR),
      .D   (stage_d),
      .Q   (stage_q[k])
    );
  end

  assign Q       = stage_q[DEPTH-1][SW-1 -: DW];
  assign OE      = stage_q[DEPTH-1][NCH:1];
  assign VLD     = stage_q[DEPTH-1][0];
  assign PEND    = pend_q;
  assign UPD_CNT = cnt_q;

endmodule : ofd_bank
`default_nettype wire

// File: tb/tb_ofd_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ofd_bank
//  Description : Self-checking bench for ofd_bank, direct and double-buffered.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ofd_bank;

  localparam int NCH = 2;
  localparam int W   = 4;
  localparam int DW  = NCH * W;
  localparam int DA  = 3;
  localparam int DB  = 4;
  localparam logic [W-1:0] INIT_A = 4'h0;
  localparam logic [W-1:0] INIT_B = 4'h6;

  typedef struct packed {
    logic [DW-1:0]  d;
    logic [NCH-1:0] oe;
    logic           v;
  } word_t;

  localparam word_t RST_A = '{d: {NCH{INIT_A}}, oe: '0, v: 1'b0};
  localparam word_t RST_B = '{d: {NCH{INIT_B}}, oe: '0, v: 1'b0};

  logic clk = 1'b0;
  logic rn = 1'b0;
  logic ce = 1'b0, clr = 1'b0, vld_in = 1'b0, ld = 1'b0, commit = 1'b0;
  logic [DW-1:0]  d = '0;
  logic [NCH-1:0] oe_in = '0, wen = '0;

  logic [DW-1:0]  q_a, q_b;
  logic [NCH-1:0] oe_a, oe_b;
  logic           vld_a, vld_b, pend_a, pend_b;
  logic [7:0]     cnt_a, cnt_b;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  ofd_bank #(.NCH(NCH), .W(W), .DEPTH(DA), .MODE(0), .INIT(INIT_A)) u_a (
    .CK(clk), .RN(rn), .CE(ce), .CLR(clr), .D(d), .VLD_IN(vld_in), .OE_IN(oe_in),
    .LD(ld), .WEN(wen), .COMMIT(commit),
    .Q(q_a), .OE(oe_a), .VLD(vld_a), .PEND(pend_a), .UPD_CNT(cnt_a)
  );

  ofd_bank #(.NCH(NCH), .W(W), .DEPTH(DB), .MODE(1), .INIT(INIT_B)) u_b (
    .CK(clk), .RN(rn), .CE(ce), .CLR(clr), .D(d), .VLD_IN(vld_in), .OE_IN(oe_in),
    .LD(ld), .WEN(wen), .COMMIT(commit),
    .Q(q_b), .OE(oe_b), .VLD(vld_b), .PEND(pend_b), .UPD_CNT(cnt_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Reference model: history of enabled captures; output is the word from DEPTH captures ago
  word_t      hist_a[$];
  word_t      hist_b[$];
  int         cnt_m_a = 0;
  int         cnt_m_b = 0;
  logic [W-1:0] sh_m [NCH] = '{default: INIT_B};
  logic       pend_m = 1'b0;
  word_t      last_b = RST_B;

  always @(posedge clk or negedge rn) begin : p_model
    word_t nb;
    if (!rn || clr) begin
      hist_a.delete();
      hist_b.delete();
      cnt_m_a = 0;
      cnt_m_b = 0;
      foreach (sh_m[i]) sh_m[i] = INIT_B;
      pend_m = 1'b0;
      last_b = RST_B;
    end else if (ce) begin
      hist_a.push_front('{d: d, oe: oe_in, v: vld_in});
      if (hist_a.size() > DA) void'(hist_a.pop_back());
      if (vld_in) cnt_m_a = (cnt_m_a + 1) % 256;

      if (commit) begin
        for (int i = 0; i < NCH; i++) nb.d[i*W +: W] = sh_m[i];
        nb.oe = oe_in;
        nb.v  = 1'b1;
        pend_m = 1'b0;
        cnt_m_b = (cnt_m_b + 1) % 256;
      end else begin
        nb = '{d: last_b.d, oe: last_b.oe, v: 1'b0};
      end
      last_b = nb;
      hist_b.push_front(nb);
      if (hist_b.size() > DB) void'(hist_b.pop_back());
      if (ld) begin
        for (int i = 0; i < NCH; i++) if (wen[i]) sh_m[i] = d[i*W +: W];
        pend_m = 1'b1;
      end
    end
  end

  always @(negedge clk) begin : p_compare
    word_t ea, eb;
    ea = (hist_a.size() == DA) ? hist_a[DA-1] : RST_A;
    eb = (hist_b.size() == DB) ? hist_b[DB-1] : RST_B;
    check("a_q",    32'(q_a),    32'(ea.d));
    check("a_oe",   32'(oe_a),   32'(ea.oe));
    check("a_vld",  32'(vld_a),  32'(ea.v));
    check("a_pend", 32'(pend_a), 32'(0));
    check("a_cnt",  32'(cnt_a),  32'(cnt_m_a));
    check("b_q",    32'(q_b),    32'(eb.d));
    check("b_oe",   32'(oe_b),   32'(eb.oe));
    check("b_vld",  32'(vld_b),  32'(eb.v));
    check("b_pend", 32'(pend_b), 32'(pend_m));
    check("b_cnt",  32'(cnt_b),  32'(cnt_m_b));
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    vld_in = 1'b0; ld = 1'b0; commit = 1'b0; clr = 1'b0;
    wen = '0; oe_in = '0; d = '0;
  endtask

  initial begin : p_watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : p_stim
    step(3);
    check("rst_q_a",   32'(q_a),   32'h00);
    check("rst_q_b",   32'(q_b),   32'h66);
    check("rst_vld_b", 32'(vld_b), 32'h0);
    check("rst_cnt_b", 32'(cnt_b), 32'h0);
    rn = 1'b1;

    // Direct mode single word through a 3-stage pipe
    ce = 1'b1; d = 8'hA5; oe_in = 2'b11; vld_in = 1'b1;
    step(1);
    vld_in = 1'b0; d = 8'h00; oe_in = 2'b00;
    step(2);
    check("t1_q_a",   32'(q_a),   32'hA5);
    check("t1_vld_a", 32'(vld_a), 32'h1);
    check("t1_cnt_a", 32'(cnt_a), 32'h1);

    // Randomized traffic on both banks
    for (int i = 0; i < 120; i++) begin
      ce     = ($urandom_range(3) != 0);
      clr    = ($urandom_range(39) == 0);
      d      = DW'($urandom);
      oe_in  = NCH'($urandom);
      wen    = NCH'($urandom);
      vld_in = $urandom_range(1);
      ld     = ($urandom_range(2) == 0);
      commit = ($urandom_range(3) == 0);
      step(1);
    end
    idle_inputs();
    ce = 1'b1;

    // Shadow loads with masks, then one commit
    clr = 1'b1; step(1); clr = 1'b0;
    ld = 1'b1; d = 8'hA5; wen = 2'b01; step(1);
    check("t3_pend1", 32'(pend_b), 32'h1);
    d = 8'h3C; wen = 2'b10; step(1);
    check("t3_pend2", 32'(pend_b), 32'h1);
    ld = 1'b0; commit = 1'b1; oe_in = 2'b11; step(1);
    check("t3_pend3", 32'(pend_b), 32'h0);
    check("t3_q_hold", 32'(q_b), 32'h66);
    commit = 1'b0; step(3);
    check("t3_q_b",   32'(q_b),   32'h35);
    check("t3_vld_b", 32'(vld_b), 32'h1);

    // Load and commit in the same cycle
    ld = 1'b1; d = 8'h11; wen = 2'b11; step(1);
    commit = 1'b1; d = 8'h22; step(1);
    ld = 1'b0; commit = 1'b0; step(3);
    check("t4_q_old", 32'(q_b),    32'h11);
    check("t4_pend",  32'(pend_b), 32'h1);
    commit = 1'b1; step(1); commit = 1'b0; step(3);
    check("t4_q_new", 32'(q_b), 32'h22);

    // Async reset with words in flight
    vld_in = 1'b1; d = 8'h77; step(1);
    d = 8'h88; commit = 1'b1; step(1);
    rn = 1'b0; #1;
    check("t5_async_q_a",   32'(q_a),   32'h00);
    check("t5_async_cnt_a", 32'(cnt_a), 32'h0);
    check("t5_async_q_b",   32'(q_b),   32'h66);
    check("t5_async_pend",  32'(pend_b), 32'h0);
    idle_inputs();
    step(1);
    rn = 1'b1;
    ld = 1'b1; d = 8'h9A; wen = 2'b11; step(1);
    // Clear wins over a simultaneous load and commit
    clr = 1'b1; d = 8'hFF; commit = 1'b1; step(1);
    clr = 1'b0; ld = 1'b0; commit = 1'b0;
    check("t5_clr_pend", 32'(pend_b), 32'h0);
    check("t5_clr_cnt",  32'(cnt_b),  32'h0);
    commit = 1'b1; step(1); commit = 1'b0; step(3);
    check("t5_clr_shadow", 32'(q_b), 32'h66);

    // Counter wrap after 256 commits
    clr = 1'b1; step(1); clr = 1'b0;
    ld = 1'b1; d = 8'h5C; wen = 2'b11; step(1);
    ld = 1'b0; d = 8'hC3;
    for (int i = 0; i < 256; i++) begin
      commit = 1'b1;
      ld     = (i == 100);
      step(1);
    end
    idle_inputs();
    step(3);
    check("t6_cnt_wrap", 32'(cnt_b),  32'h0);
    check("t6_q_b",      32'(q_b),    32'hC3);
    check("t6_pend",     32'(pend_b), 32'h0);

    step(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_ofd_bank
`default_nettype wire
